bcd_count_scan: RTL
===================

Name: bcd_count_scan

Overview:
- Downstream consumer of the frequency-divider stage in the BCD counter / segment-display design.
- Takes the divider's slow tick as a one-cycle enable in the mclk domain and keeps an NDIG-digit BCD up/down count.
- Drives a time-multiplexed common-anode 7-segment display from that count.
- Single clock domain (mclk). Nothing in the count path is clocked by a divided clock.

Parameters:
- NDIG, 4, number of BCD digits and anodes (2..8).
- SCAN_DIV, 50000, mclk cycles each digit is displayed before the scan advances (>=2).
- SEG_ACT_LOW, 1, 1 = segment outputs active-low; 0 = active-high.
- AN_ACT_LOW, 1, 1 = anode outputs active-low; 0 = active-high.

Ports:
- mclk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  one-mclk-cycle count strobe from the frequency divider.
- en  in  1  count enable; tick is ignored when low.
- up_dn  in  1  1 = count up, 0 = count down.
- clr  in  1  synchronous clear of the count only; the scan keeps running.
- count  out  4*NDIG  packed BCD count; digit 0 is in bits [3:0].
- carry  out  1  one-cycle pulse on wrap, in either count direction.
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW.
- an  out  NDIG  one-hot digit select, polarity per AN_ACT_LOW.

Behaviour:
- Reset (rst=1 at a clock edge):
  - count=0, carry=0, scan prescaler=0, digit index=0.
  - an = all inactive; seg = all segments off.
  - Reset asserted mid-count or mid-scan behaves the same; no state survives it.
- Count update, in priority order:
  - clr=1: count=0, carry=0.
  - tick=1 and en=1: step the count, registered on the same edge as the tick.
  - Otherwise: count holds and carry=0.
- Up count: digit 0 increments. A digit at 9 becomes 0 and propagates a carry into the next digit.
- Up wrap: all digits 9 goes to all 0 with carry=1 for exactly one cycle.
- Down count: a digit at 0 becomes 9 and propagates a borrow. All 0 goes to all 9 with carry=1 for one cycle.
- carry is registered and aligned with the count value produced by the wrap.
- Direction: up_dn is sampled only on the tick cycle. Changing it between ticks has no effect.
- Simultaneous clr and tick: clr wins and no carry is produced.
- Back-to-back ticks (tick held high): one step per cycle. This is legal and must be correct at the wrap.
- Illegal BCD nibbles (>9) cannot be produced.
- Scan prescaler: counts 0..SCAN_DIV-1 and wraps. On the wrap cycle the digit index advances, NDIG-1 wrapping to 0.
- Display outputs:
  - Registered from the current digit index and the current count, so one cycle of latency.
  - The cycle after reset release, an selects digit 0 and seg shows count digit 0.
  - A count change appears on seg the cycle after count updates, if that digit is currently selected.
- Segment decode (active-high pattern gfedcba), inverted when SEG_ACT_LOW=1:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Any other nibble decodes to blank. This is a defensive case only.
- No leading-zero blanking.

Decomposition:
- Shared package bcd_seg_pkg holds:
  - the 7-bit segment constants for 0-9 and SEG_BLANK;
  - a function bcd_to_seg(nibble) returning the active-high pattern.
- Natural sub-module: bcd_digit. One BCD digit with inc, dec and clr inputs, plus carry-in and carry-out or borrow-out. Instantiated NDIG times in a chain.
- The scan and decode logic stays in the top module.

Test Plan (SCAN_DIV=4, NDIG=4, active-low outputs):
- Reset release, no ticks: the next cycle gives an=1110, seg=1000000 (digit 0 shows "0"); every 4 cycles an rotates 1101, 1011, 0111, 1110.
- up_dn=1, en=1, 12 single-cycle ticks from 0: count=16'h0012; carry never asserted.
- Preload to 9999 via 9999 up ticks, then 1 more tick: count=0000 and carry=1 for exactly one cycle.
- From 0000, up_dn=0, 1 tick: count=9999 with a one-cycle carry; then 1 more tick gives count=9998 and carry=0.
- From 0037, pulse tick and clr in the same cycle: count=0000 and carry=0. With en=0 and ticks applied: count holds.
- Assert rst mid-scan while an=1011 and count=0420: the next cycle has count=0, an=1111, seg=1111111; one cycle after release, an=1110 and seg=1000000.

Source files
------------

// File: rtl/bcd_seg_pkg.sv
// rtl/bcd_seg_pkg.sv - segment patterns and BCD-to-segment decode
// Patterns are active-high gfedcba; output polarity is applied by the user.
package bcd_seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
      case (nibble)
         4'd0:    bcd_to_seg = SEG_0;
         4'd1:    bcd_to_seg = SEG_1;
         4'd2:    bcd_to_seg = SEG_2;
         4'd3:    bcd_to_seg = SEG_3;
         4'd4:    bcd_to_seg = SEG_4;
         4'd5:    bcd_to_seg = SEG_5;
         4'd6:    bcd_to_seg = SEG_6;
         4'd7:    bcd_to_seg = SEG_7;
         4'd8:    bcd_to_seg = SEG_8;
         4'd9:    bcd_to_seg = SEG_9;
         default: bcd_to_seg = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bcd_count_scan_if.sv
// rtl/bcd_count_scan_if.sv - control strobes in, count and display out
// The master drives tick/en/up_dn/clr; the slave (counter) drives the rest.
interface bcd_count_scan_if #(parameter int NDIG = 4);

   logic              tick;
   logic              en;
   logic              up_dn;
   logic              clr;
   logic [4*NDIG-1:0] count;
   logic              carry;
   logic [6:0]        seg;
   logic [NDIG-1:0]   an;

   modport master (output tick, en, up_dn, clr, input count, carry, seg, an);
   modport slave  (input tick, en, up_dn, clr, output count, carry, seg, an);

endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit of the up/down chain
// Steps only when cin is set; cout flags a carry (up) or borrow (down).
module bcd_digit (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   input  logic       dec,
   input  logic       cin,
   output logic [3:0] q,
   output logic       cout
);

   assign cout = cin & ((inc & (q == 4'd9)) | (dec & (q == 4'd0)));

   // Values above 9 are folded back to 0/9 so the digit can never leave BCD range.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= 4'd0;
      end else if (cin && inc) begin
         q <= (q >= 4'd9) ? 4'd0 : q + 4'd1;
      end else if (cin && dec) begin
         q <= (q == 4'd0 || q > 4'd9) ? 4'd9 : q - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_count_scan.sv
// rtl/bcd_count_scan.sv - BCD up/down counter with multiplexed 7-segment scan
// All state runs on mclk; tick is a one-cycle enable, not a clock.
module bcd_count_scan
   import bcd_seg_pkg::*;
#(
   parameter int NDIG        = 4,
   parameter int SCAN_DIV    = 50000,
   parameter int SEG_ACT_LOW = 1,
   parameter int AN_ACT_LOW  = 1
) (
   input  logic             mclk,
   input  logic             rst,
   bcd_count_scan_if.slave  bus
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic              step_up;
   logic              step_dn;
   logic [NDIG:0]     chain;
   logic [4*NDIG-1:0] cnt;
   logic              carry_r;
   logic [PW-1:0]     psc;
   logic [IW-1:0]     idx;
   logic [3:0]        cur;
   logic [NDIG-1:0]   an_hot;
   logic [6:0]        seg_pat;
   logic [NDIG-1:0]   an_r;
   logic [6:0]        seg_r;

   assign step_up  = bus.tick & bus.en & bus.up_dn;
   assign step_dn  = bus.tick & bus.en & ~bus.up_dn;
   assign chain[0] = 1'b1;

   for (genvar i = 0; i < NDIG; i++) begin : g_dig
      bcd_digit u_dig (
         .clk  (mclk),
         .rst  (rst),
         .clr  (bus.clr),
         .inc  (step_up),
         .dec  (step_dn),
         .cin  (chain[i]),
         .q    (cnt[4*i +: 4]),
         .cout (chain[i+1])
      );
   end

   // The chain's last carry is only high on a stepping cycle, so carry self-clears.
   always_ff @(posedge mclk) begin
      if (rst || bus.clr) carry_r <= 1'b0;
      else                carry_r <= chain[NDIG];
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         psc <= '0;
         idx <= '0;
      end else if (psc == PW'(SCAN_DIV - 1)) begin
         psc <= '0;
         idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
      end else begin
         psc <= psc + 1'b1;
      end
   end

   always_comb begin
      cur    = 4'd0;
      an_hot = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx == IW'(i)) begin
            cur       = cnt[4*i +: 4];
            an_hot[i] = 1'b1;
         end
      end
      seg_pat = bcd_to_seg(cur);
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         an_r  <= (AN_ACT_LOW != 0) ? '1 : '0;
         seg_r <= (SEG_ACT_LOW != 0) ? 7'h7f : 7'h00;
      end else begin
         an_r  <= (AN_ACT_LOW != 0) ? ~an_hot : an_hot;
         seg_r <= (SEG_ACT_LOW != 0) ? ~seg_pat : seg_pat;
      end
   end

   assign bus.count = cnt;
   assign bus.carry = carry_r;
   assign bus.an    = an_r;
   assign bus.seg   = seg_r;

endmodule
